// File: rtl/core_seq_ctrl.sv
// core_seq_ctrl: drives the core inst bus through one full tile per start pulse.
// Latency: inst/busy/done are registered. The first weight read is one cycle after start; done is 66 cycles after start at row=col=n_act=8.
// Backpressure: OUT issues a psum write only after a cycle with ofifo_valid high, otherwise it stalls on the idle value with no timeout.
module core_seq_ctrl #(
   parameter int row     = 8,
   parameter int col     = 8,
   parameter int addr_bw = 11,
   parameter int cnt_bw  = 8
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic               acc_en,
   input  logic [addr_bw-1:0] w_base,
   input  logic [addr_bw-1:0] x_base,
   input  logic [addr_bw-1:0] p_base,
   input  logic [cnt_bw-1:0]  n_act,
   input  logic               ofifo_valid,
   output logic [33:0]        inst,
   output logic               busy,
   output logic               done
);

   typedef enum logic [3:0] {
      S_IDLE, S_SKIP, S_WRD, S_WLD, S_GAP, S_ARD, S_EXE, S_DRN, S_OUT, S_DONE
   } state_t;

   // Idle value: both SRAM CEN/WEN high (inactive), everything else low.
   localparam logic [33:0]       INST_IDLE = 34'h1_800C_0000;
   localparam logic [cnt_bw-1:0] WRD_LAST  = cnt_bw'(row - 1);
   localparam logic [cnt_bw-1:0] LD_LAST   = cnt_bw'(row + col - 1);

   state_t             state, state_nxt;
   logic [cnt_bw-1:0]  cnt, cnt_nxt;   // cycle index k within the current phase
   logic [cnt_bw-1:0]  j, j_nxt;       // psum writes issued so far
   logic [cnt_bw-1:0]  n_q;
   logic [addr_bw-1:0] w_q, x_q, p_q, w_b;
   logic               acc_q, acc_b, wr_nxt;
   logic [33:0]        inst_nxt;

   // Next state, counters and the instruction for the coming cycle.
   // inst is computed from the state being entered, so it is aligned with state.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      j_nxt     = j;
      inst_nxt  = INST_IDLE;
      wr_nxt    = 1'b0;
      // Bases are latched at the same edge that leaves IDLE, so use the live inputs then.
      w_b       = (state == S_IDLE) ? w_base : w_q;
      acc_b     = (state == S_IDLE) ? acc_en : acc_q;

      case (state)
         S_IDLE: if (start) begin
            cnt_nxt   = '0;
            j_nxt     = '0;
            state_nxt = (n_act == '0) ? S_SKIP : S_WRD;
         end
         S_SKIP: state_nxt = S_DONE;
         S_WRD: if (cnt == WRD_LAST) begin state_nxt = S_WLD; cnt_nxt = '0; end
                else cnt_nxt = cnt + cnt_bw'(1);
         S_WLD: if (cnt == LD_LAST) begin state_nxt = S_GAP; cnt_nxt = '0; end
                else cnt_nxt = cnt + cnt_bw'(1);
         S_GAP: begin state_nxt = S_ARD; cnt_nxt = '0; end
         S_ARD: if (cnt == n_q - cnt_bw'(1)) begin state_nxt = S_EXE; cnt_nxt = '0; end
                else cnt_nxt = cnt + cnt_bw'(1);
         S_EXE: if (cnt == n_q - cnt_bw'(1)) begin state_nxt = S_DRN; cnt_nxt = '0; end
                else cnt_nxt = cnt + cnt_bw'(1);
         S_DRN: if (cnt == LD_LAST) begin state_nxt = S_OUT; cnt_nxt = '0; end
                else cnt_nxt = cnt + cnt_bw'(1);
         S_OUT: if (j == n_q) state_nxt = S_DONE;
         S_DONE: state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase

      // ofifo_valid is sampled here, so a write lands in the cycle after valid was seen.
      wr_nxt = (state_nxt == S_OUT) && ofifo_valid && (j != n_q);
      if (wr_nxt) j_nxt = j + cnt_bw'(1);

      if (state_nxt != S_IDLE) begin
         inst_nxt[33] = acc_b;
         // xmem data appears one cycle after the read, so l0_wr trails any read cycle.
         inst_nxt[2]  = ~inst[19];
      end

      case (state_nxt)
         S_WRD: begin
            inst_nxt[19]   = 1'b0;
            inst_nxt[17:7] = w_b + addr_bw'(cnt_nxt);
         end
         S_WLD: begin
            inst_nxt[3] = 1'b1;
            inst_nxt[0] = 1'b1;
         end
         S_ARD: begin
            inst_nxt[19]   = 1'b0;
            inst_nxt[17:7] = x_q + addr_bw'(cnt_nxt);
         end
         S_EXE: begin
            inst_nxt[3] = 1'b1;
            inst_nxt[1] = 1'b1;
         end
         S_OUT: if (wr_nxt) begin
            inst_nxt[32]    = 1'b0;
            inst_nxt[31]    = 1'b0;
            inst_nxt[30:20] = p_q + addr_bw'(j);
            inst_nxt[6]     = 1'b1;
         end
         default: ;
      endcase
   end

   // State, counters, latched tile parameters and registered outputs; reset aborts at once.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= S_IDLE;
         cnt   <= '0;
         j     <= '0;
         n_q   <= '0;
         w_q   <= '0;
         x_q   <= '0;
         p_q   <= '0;
         acc_q <= 1'b0;
         inst  <= INST_IDLE;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         j     <= j_nxt;
         inst  <= inst_nxt;
         busy  <= (state_nxt != S_IDLE);
         done  <= (state_nxt == S_DONE);
         if (state == S_IDLE && start) begin
            w_q   <= w_base;
            x_q   <= x_base;
            p_q   <= p_base;
            n_q   <= n_act;
            acc_q <= acc_en;
         end
      end
   end

endmodule

// File: tb/tb_core_seq_ctrl.sv
// tb_core_seq_ctrl: directed bench for the tile sequencer.
// Latency: checks done timing, SRAM address sequences and pulse counts per tile.
// Backpressure: exercises ofifo_valid stalls in OUT.
module tb_core_seq_ctrl;

   localparam logic [33:0] INST_IDLE = 34'h1_800C_0000;

   logic        clk = 1'b0;
   logic        reset, start, acc_en, ofifo_valid;
   logic [10:0] w_base, x_base, p_base;
   logic [7:0]  n_act;
   logic [33:0] inst;
   logic        busy, done;

   core_seq_ctrl dut (
      .clk(clk), .reset(reset), .start(start), .acc_en(acc_en),
      .w_base(w_base), .x_base(x_base), .p_base(p_base), .n_act(n_act),
      .ofifo_valid(ofifo_valid), .inst(inst), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: collects SRAM traffic and pulse counts at the falling edge.
   logic [10:0] xq[$];
   logic [10:0] pq[$];
   int done_cnt = 0, done_cyc = 0, busy_cnt = 0, acc_low = 0;
   int l0wr_cnt = 0, load_cnt = 0, exe_cnt = 0;
   always @(negedge clk) begin
      if (!inst[19]) xq.push_back(inst[17:7]);
      if (!inst[32] && !inst[31]) pq.push_back(inst[30:20]);
      if (done) begin done_cnt++; done_cyc = cyc; end
      if (busy) busy_cnt++;
      if (busy && !inst[33]) acc_low++;
      if (inst[2]) l0wr_cnt++;
      if (inst[0]) load_cnt++;
      if (inst[1]) exe_cnt++;
   end

   int errors = 0;
   int checks = 0;
   int s_cyc, d0, x0, p0, b0, w0, l0, e0, a0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic snap();
      d0 = done_cnt; x0 = xq.size(); p0 = pq.size(); b0 = busy_cnt;
      w0 = l0wr_cnt; l0 = load_cnt; e0 = exe_cnt; a0 = acc_low;
   endtask

   task automatic launch(input logic [10:0] w, input logic [10:0] x, input logic [10:0] p,
                         input logic [7:0] n, input logic acc);
      snap();
      w_base = w; x_base = x; p_base = p; n_act = n; acc_en = acc;
      start = 1'b1;
      s_cyc = cyc;
      tick();
      start = 1'b0;
   endtask

   task automatic wait_done(input string tag);
      for (int i = 0; i < 300 && done_cnt == d0; i++) tick();
      chk(tag, 64'(done_cnt != d0), 64'd1);
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; acc_en = 1'b0; ofifo_valid = 1'b1;
      w_base = '0; x_base = '0; p_base = '0; n_act = '0;
      repeat (3) tick();
      chk("rst_inst", 64'(inst), 64'(INST_IDLE));
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      reset = 1'b0;
      repeat (2) tick();

      // Full tile: weights 0..7, activations 16..23, psums 0..7, done at 66.
      launch(11'd0, 11'd16, 11'd0, 8'd8, 1'b0);
      chk("t2_busy_rise", 64'(busy), 64'd1);
      wait_done("t2_done_seen");
      chk("t2_done_time", 64'(done_cyc - s_cyc), 64'd66);
      chk("t2_xreads", 64'(xq.size() - x0), 64'd16);
      for (int i = 0; i < 16; i++)
         chk($sformatf("t2_xaddr%0d", i), 64'(xq[x0 + i]), (i < 8) ? 64'(i) : 64'(16 + i - 8));
      chk("t2_pwrites", 64'(pq.size() - p0), 64'd8);
      for (int i = 0; i < 8; i++) chk($sformatf("t2_paddr%0d", i), 64'(pq[p0 + i]), 64'(i));
      chk("t2_l0wr", 64'(l0wr_cnt - w0), 64'd16);
      chk("t2_load", 64'(load_cnt - l0), 64'd16);
      chk("t2_exec", 64'(exe_cnt - e0), 64'd8);
      chk("t2_busy_cycles", 64'(busy_cnt - b0), 64'd66);
      chk("t2_acc_low", 64'(acc_low - a0), 64'd66);
      tick();
      chk("t2_done_pulse", 64'(done), 64'd0);
      chk("t2_busy_fall", 64'(busy), 64'd0);
      chk("t2_idle_inst", 64'(inst), 64'(INST_IDLE));

      // Same tile with ofifo_valid alternating in OUT: writes at c58,59,61,...,71 -> done at 72.
      launch(11'd0, 11'd16, 11'd0, 8'd8, 1'b0);
      while (cyc < s_cyc + 59) tick();
      for (int i = 0; i < 100 && done_cnt == d0; i++) begin
         ofifo_valid = ((cyc - s_cyc) % 2 == 0);
         tick();
      end
      ofifo_valid = 1'b1;
      chk("t3_done_seen", 64'(done_cnt != d0), 64'd1);
      chk("t3_done_time", 64'(done_cyc - s_cyc), 64'd72);
      chk("t3_pwrites", 64'(pq.size() - p0), 64'd8);
      for (int i = 0; i < 8; i++) chk($sformatf("t3_paddr%0d", i), 64'(pq[p0 + i]), 64'(i));
      repeat (2) tick();

      // Reset asserted mid-EXE, between clock edges.
      launch(11'd0, 11'd16, 11'd0, 8'd8, 1'b0);
      for (int i = 0; i < 200 && !inst[1]; i++) tick();
      chk("t1_exe_reached", 64'(inst[1]), 64'd1);
      tick();
      #2;
      reset = 1'b1;
      #1;
      chk("t1_abort_inst", 64'(inst), 64'(INST_IDLE));
      chk("t1_abort_busy", 64'(busy), 64'd0);
      chk("t1_no_pwrite", 64'(pq.size() - p0), 64'd0);
      tick();
      reset = 1'b0;
      tick();

      // Clean tile after the abort, with wrapping bases.
      launch(11'd2044, 11'd2046, 11'd2047, 8'd3, 1'b0);
      wait_done("t4_done_seen");
      chk("t4_done_time", 64'(done_cyc - s_cyc), 64'd51);
      chk("t4_xreads", 64'(xq.size() - x0), 64'd11);
      for (int i = 0; i < 8; i++)
         chk($sformatf("t4_waddr%0d", i), 64'(xq[x0 + i]), 64'((2044 + i) % 2048));
      chk("t4_aaddr0", 64'(xq[x0 + 8]), 64'd2046);
      chk("t4_aaddr1", 64'(xq[x0 + 9]), 64'd2047);
      chk("t4_aaddr2", 64'(xq[x0 + 10]), 64'd0);
      chk("t4_pwrites", 64'(pq.size() - p0), 64'd3);
      chk("t4_paddr0", 64'(pq[p0]), 64'd2047);
      chk("t4_paddr1", 64'(pq[p0 + 1]), 64'd0);
      chk("t4_paddr2", 64'(pq[p0 + 2]), 64'd1);
      repeat (2) tick();

      // Empty tile: done two cycles after start, no SRAM traffic.
      launch(11'd5, 11'd6, 11'd7, 8'd0, 1'b0);
      wait_done("t5_done_seen");
      chk("t5_done_time", 64'(done_cyc - s_cyc), 64'd2);
      chk("t5_xreads", 64'(xq.size() - x0), 64'd0);
      chk("t5_pwrites", 64'(pq.size() - p0), 64'd0);
      repeat (2) tick();

      // acc latched at start; a start pulse during EXE is ignored.
      launch(11'd0, 11'd16, 11'd0, 8'd8, 1'b1);
      acc_en = 1'b0;
      for (int i = 0; i < 200 && !inst[1]; i++) tick();
      chk("t6_exe_reached", 64'(inst[1]), 64'd1);
      w_base = 11'd100; n_act = 8'd0;
      start = 1'b1;
      tick();
      start = 1'b0;
      wait_done("t6_done_seen");
      chk("t6_done_time", 64'(done_cyc - s_cyc), 64'd66);
      chk("t6_acc_held", 64'(acc_low - a0), 64'd0);
      chk("t6_busy_cycles", 64'(busy_cnt - b0), 64'd66);
      chk("t6_xaddr0", 64'(xq[x0]), 64'd0);
      repeat (10) tick();
      chk("t6_one_done", 64'(done_cnt - d0), 64'd1);
      chk("t6_idle_busy", 64'(busy), 64'd0);
      chk("t6_idle_acc", 64'(inst[33]), 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
